// File: rtl/simon_blk_packer.sv
// -----------------------------------------------------------------------------
// simon_blk_packer
//
// Packs an incoming byte stream into one Simon cipher block per output beat.
// The byte at position k of a block lands in blk_out[BLOCK_BITS-1-8k -: 8], so
// the first byte of a block is its most-significant byte. A message that ends
// before the block is full produces a zero-padded short block. blk_out_nbytes
// reports how many bytes of that block are valid.
//
// Handshake rule, used on both sides: a transfer happens on a rising clk edge
// where valid and ready are both high. Once valid is raised it stays high,
// and the payload stays unchanged, until that transfer happens.
//
// Parameters:
//   BLOCK_BITS      Simon block size in bits: 32, 48, 64, 96 or 128
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-high reset
//   byte_in         input byte
//   byte_in_vld     byte_in valid
//   byte_in_last    last byte of a message (qualified by byte_in_vld)
//   byte_in_rdy     packer can accept a byte
//   blk_out         packed block, bits [255:BLOCK_BITS] always zero
//   blk_out_nbytes  number of valid bytes in blk_out (1..NB while valid)
//   blk_out_last    block holds the last byte of the message
//   blk_out_vld     block valid
//   blk_out_rdy     consumer ready
// -----------------------------------------------------------------------------
module simon_blk_packer #(
  parameter int BLOCK_BITS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_in_vld,
  input  logic         byte_in_last,
  output logic         byte_in_rdy,
  output logic [255:0] blk_out,
  output logic [4:0]   blk_out_nbytes,
  output logic         blk_out_last,
  output logic         blk_out_vld,
  input  logic         blk_out_rdy
);

  localparam int NB = BLOCK_BITS / 8;

  if (BLOCK_BITS != 32 && BLOCK_BITS != 48 && BLOCK_BITS != 64 &&
      BLOCK_BITS != 96 && BLOCK_BITS != 128) begin : g_bad_block_bits
    $error("simon_blk_packer: BLOCK_BITS must be 32, 48, 64, 96 or 128");
  end

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [BLOCK_BITS-1:0]   blk_q, blk_d;
  logic [4:0]              nb_q, nb_d;
  logic                    last_q, last_d;
  logic                    accept;

  // Writes byte b at block position pos (position 0 is the MSB byte).
  // The loop keeps every part-select constant.
  function automatic logic [BLOCK_BITS-1:0] put_byte(
    input logic [BLOCK_BITS-1:0] blk,
    input logic [3:0]            pos,
    input logic [7:0]            b
  );
    logic [BLOCK_BITS-1:0] r;
    r = blk;
    for (int k = 0; k < NB; k++) begin
      if (4'(k) == pos) begin
        r[BLOCK_BITS-1-8*k -: 8] = b;
      end
    end
    return r;
  endfunction

  // In FULL the input side follows the consumer, so a byte can enter
  // on the same edge that the finished block leaves.
  assign byte_in_rdy = (state_q == FILL) ? 1'b1 : blk_out_rdy;
  assign accept      = byte_in_vld && byte_in_rdy;

  assign blk_out_vld    = (state_q == FULL);
  assign blk_out        = {{(256-BLOCK_BITS){1'b0}}, blk_q};
  assign blk_out_nbytes = nb_q;
  assign blk_out_last   = last_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    nb_d    = nb_q;
    last_d  = last_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          blk_d = put_byte(blk_q, cnt_q, byte_in);
          if (cnt_q == 4'(NB-1) || byte_in_last) begin
            state_d = FULL;
            nb_d    = {1'b0, cnt_q} + 5'd1;
            last_d  = byte_in_last;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      FULL: begin
        if (blk_out_rdy) begin
          if (accept) begin
            // Handoff and first byte of the next block on one edge.
            // The register is cleared so a short block is zero-padded.
            blk_d = put_byte('0, 4'd0, byte_in);
            if (byte_in_last) begin
              state_d = FULL;
              nb_d    = 5'd1;
              last_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = FILL;
              nb_d    = '0;
              last_d  = 1'b0;
              cnt_d   = 4'd1;
            end
          end else begin
            state_d = FILL;
            blk_d   = '0;
            nb_d    = '0;
            last_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      blk_q   <= '0;
      nb_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      nb_q    <= nb_d;
      last_q  <= last_d;
    end
  end

  // The byte position never leaves the block.
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= 4'(NB-1));

  // A stalled output beat keeps its payload.
  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (blk_out_vld && !blk_out_rdy) |=>
      (blk_out_vld && $stable(blk_q) && $stable(nb_q) && $stable(last_q)));

endmodule
